// File: rtl/pio_edge_irq_multi.sv
// ---------------------------------------------------------------------------
// pio_edge_irq_multi
//   Avalon-MM parallel I/O block: generic input port with per-bit 2-FF
//   synchroniser, optional debounce and selectable edge capture, plus a
//   generic output port with atomic SET/CLR writes and a maskable level irq.
//
//   Build option: define PIO_DEBOUNCE_EN to build the per-bit debouncers.
//   Without it DATA_IN is the synchroniser output directly.
//
// Ports
//   clk_clk        single clock for all logic
//   reset_reset_n  asynchronous active-low reset
//   avs_address    word address (0..7)
//   avs_read       read strobe; avs_readdata valid the following cycle
//   avs_write      write strobe; takes effect on the same clock edge
//   avs_writedata  write data
//   avs_readdata   registered read data, held while avs_read is low
//   pio_in         asynchronous external inputs
//   pio_out        registered outputs
//   irq            level interrupt, |(edge_capture & irq_mask)
//
// Register map
//   0 DATA_IN  RO   1 DATA_OUT RW   2 SET WO   3 CLR WO
//   4 IRQ_MASK RW   5 EDGE_CAP RW1C 6 EDGE_CFG RW [1:0]   7 reserved
// ---------------------------------------------------------------------------

`ifdef PIO_DEBOUNCE_EN
// Single-bit debouncer. Exposes both the registered debounced value and its
// next-state value so the parent can detect edges on the same clock edge the
// debounced value changes.
module pio_edge_irq_multi_deb #(
    parameter int   CYCLES  = 16,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic deb_d_o,
    output logic deb_q_o
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Counter runs only while the synchronised input disagrees with the
    // debounced value; the CYCLES-th disagreeing cycle accepts the change.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync_i != deb_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                deb_d = sync_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            deb_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_d_o = deb_d;
    assign deb_q_o = deb_q;
endmodule
`endif

module pio_edge_irq_multi #(
    parameter int                   IN_WIDTH        = 10,
    parameter int                   OUT_WIDTH       = 10,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0,
    parameter logic [IN_WIDTH-1:0]  IN_RESET        = '0,
    parameter int                   DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out,
    output logic                 irq
);
    localparam logic [2:0] A_DIN  = 3'd0;
    localparam logic [2:0] A_DOUT = 3'd1;
    localparam logic [2:0] A_SET  = 3'd2;
    localparam logic [2:0] A_CLR  = 3'd3;
    localparam logic [2:0] A_MASK = 3'd4;
    localparam logic [2:0] A_CAP  = 3'd5;
    localparam logic [2:0] A_CFG  = 3'd6;

    logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
    logic [IN_WIDTH-1:0]  din_d, din_q;
    logic [IN_WIDTH-1:0]  mask_q, mask_d;
    logic [IN_WIDTH-1:0]  cap_q, cap_d;
    logic [IN_WIDTH-1:0]  rise, fall, sel;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [1:0]           cfg_q, cfg_d;
    logic [31:0]          rd_q, rd_d;

    // Upper write-data bits are legitimately ignored for narrow ports.
    logic unused_wd;
    assign unused_wd = ^avs_writedata;

    // ---------------- input synchroniser ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= IN_RESET;
            sync2_q <= IN_RESET;
        end else begin
            sync1_q <= pio_in;
            sync2_q <= sync1_q;
        end
    end

    // din_q is DATA_IN; din_d is its next-state value. Edges are taken as
    // din_d vs din_q, i.e. new DATA_IN against its one-cycle-delayed copy,
    // so a capture bit sets on the same clock edge that DATA_IN changes.
`ifdef PIO_DEBOUNCE_EN
    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_deb
        pio_edge_irq_multi_deb #(
            .CYCLES  (DEBOUNCE_CYCLES),
            .RST_VAL (IN_RESET[i])
        ) u_deb (
            .clk_i   (clk_clk),
            .rst_ni  (reset_reset_n),
            .sync_i  (sync2_q[i]),
            .deb_d_o (din_d[i]),
            .deb_q_o (din_q[i])
        );
    end
`else
    localparam int unused_deb_cycles = DEBOUNCE_CYCLES;
    assign din_d = sync1_q;
    assign din_q = sync2_q;
`endif

    // ---------------- edge detect / capture ----------------
    assign rise = din_d & ~din_q;
    assign fall = ~din_d & din_q;

    always_comb begin
        case (cfg_q)
            2'b00:   sel = rise;
            2'b01:   sel = fall;
            2'b10:   sel = rise | fall;
            default: sel = '0;
        endcase
    end

    // ---------------- register writes ----------------
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        cfg_d  = cfg_q;
        cap_d  = cap_q;
        if (avs_write) begin
            case (avs_address)
                A_DOUT: out_d  = avs_writedata[OUT_WIDTH-1:0];
                A_SET:  out_d  = out_q | avs_writedata[OUT_WIDTH-1:0];
                A_CLR:  out_d  = out_q & ~avs_writedata[OUT_WIDTH-1:0];
                A_MASK: mask_d = avs_writedata[IN_WIDTH-1:0];
                A_CAP:  cap_d  = cap_q & ~avs_writedata[IN_WIDTH-1:0];
                A_CFG:  cfg_d  = avs_writedata[1:0];
                default: ;
            endcase
        end
        // New edges applied after the W1C so a coincident set wins.
        cap_d = cap_d | sel;
    end

    // ---------------- read mux ----------------
    always_comb begin
        rd_d = '0;
        case (avs_address)
            A_DIN:  rd_d[IN_WIDTH-1:0]  = din_q;
            A_DOUT: rd_d[OUT_WIDTH-1:0] = out_q;
            A_MASK: rd_d[IN_WIDTH-1:0]  = mask_q;
            A_CAP:  rd_d[IN_WIDTH-1:0]  = cap_q;
            A_CFG:  rd_d[1:0]           = cfg_q;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_q  <= OUT_RESET;
            mask_q <= '0;
            cfg_q  <= 2'b00;
            cap_q  <= '0;
            rd_q   <= '0;
        end else begin
            out_q  <= out_d;
            mask_q <= mask_d;
            cfg_q  <= cfg_d;
            cap_q  <= cap_d;
            if (avs_read) rd_q <= rd_d;
        end
    end

    assign avs_readdata = rd_q;
    assign pio_out      = out_q;
    assign irq          = |(cap_q & mask_q);
endmodule

// File: tb/tb_pio_edge_irq_multi.sv
module tb_pio_edge_irq_multi;
    localparam int W = 10;
`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = 6;   // 2 sync + 4 debounce
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    addr = '0;
    logic          rd = 1'b0, wr = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic [W-1:0]  pin = '0;
    logic [W-1:0]  pout;
    logic          irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    pio_edge_irq_multi #(
        .IN_WIDTH(W), .OUT_WIDTH(W), .OUT_RESET('0), .IN_RESET('0), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_read(rd),
        .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdata),
        .pio_in(pin), .pio_out(pout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    // Expected value queued at issue, popped when readdata becomes valid.
    task automatic bus_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    initial begin
        // ---- reset ----
        tick(2);
        chk("rst_pio_out", 32'(pout), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_readdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) bus_rd(3'(a), 32'h0, $sformatf("rst_reg%0d", a));

        // ---- output writes ----
        bus_wr(3'd1, 32'h0F0);
        bus_wr(3'd2, 32'h00F);
        chk("set_pio_out", 32'(pout), 32'h0FF);
        bus_wr(3'd3, 32'h0F0);
        chk("clr_pio_out", 32'(pout), 32'h00F);
        bus_rd(3'd0, 32'h0, "din_before");
        bus_rd(3'd1, 32'h00F, "dout_rd_lat1");
        tick();
        chk("rd_hold", rdata, 32'h00F);
        bus_rd(3'd2, 32'h0, "set_reads0");
        bus_rd(3'd3, 32'h0, "clr_reads0");

        // ---- debounce + irq ----
        bus_wr(3'd4, 32'h001);
        bus_rd(3'd4, 32'h001, "mask_rd");
`ifdef PIO_DEBOUNCE_EN
        pin[0] = 1'b1;
        tick(3);
        pin[0] = 1'b0;
        tick(8);
        chk("glitch_irq", 32'(irq), 32'h0);
        bus_rd(3'd0, 32'h0, "glitch_din");
        bus_rd(3'd5, 32'h0, "glitch_cap");
`endif
        pin[0] = 1'b1;
        tick(LAT - 1);
        chk("rise_irq_early", 32'(irq), 32'h0);
        tick();
        chk("rise_irq", 32'(irq), 32'h1);
        bus_rd(3'd0, 32'h001, "rise_din");
        bus_rd(3'd5, 32'h001, "rise_cap");
        bus_wr(3'd5, 32'h001);
        chk("w1c_irq", 32'(irq), 32'h0);
        bus_rd(3'd5, 32'h0, "w1c_cap");

        // W1C landing on the same edge as a new (falling) capture
        bus_wr(3'd6, 32'h2);
        pin[0] = 1'b0;
        tick(LAT - 1);
        chk("coll_irq_pre", 32'(irq), 32'h0);
        bus_wr(3'd5, 32'h001);
        chk("coll_irq", 32'(irq), 32'h1);
        bus_rd(3'd5, 32'h001, "coll_cap");
        bus_wr(3'd5, 32'h001);
        chk("coll_clear_irq", 32'(irq), 32'h0);

        // ---- edge cfg ----
        bus_wr(3'd4, 32'h3FF);
        bus_wr(3'd6, 32'h1);
        pin[3] = 1'b1;
        tick(LAT + 2);
        chk("fallcfg_rise_irq", 32'(irq), 32'h0);
        bus_rd(3'd5, 32'h0, "fallcfg_rise_cap");
        pin[3] = 1'b0;
        tick(LAT + 2);
        chk("fallcfg_fall_irq", 32'(irq), 32'h1);
        bus_rd(3'd5, 32'h008, "fallcfg_fall_cap");
        bus_rd(3'd6, 32'h1, "cfg_rd");
        bus_wr(3'd6, 32'h3);
        bus_rd(3'd5, 32'h008, "cfg_keeps_cap");
        bus_wr(3'd5, 32'h008);
        pin[3] = 1'b1;
        tick(LAT + 2);
        pin[3] = 1'b0;
        tick(LAT + 2);
        bus_rd(3'd5, 32'h0, "cfg_off_cap");
        chk("cfg_off_irq", 32'(irq), 32'h0);

        // ---- ignored writes / truncation ----
        pin[5] = 1'b1;
        tick(LAT + 2);
        bus_wr(3'd0, 32'h3FF);
        bus_rd(3'd0, 32'h020, "din_ro");
        bus_wr(3'd7, 32'hFFFF_FFFF);
        bus_rd(3'd7, 32'h0, "reserved");
        bus_wr(3'd1, 32'hFFFF_FFFF);
        chk("dout_trunc", 32'(pout), 32'h3FF);
        bus_rd(3'd1, 32'h3FF, "dout_trunc_rd");

        // ---- mid-cycle reset; pio_in[5] stays high through it ----
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pio_out", 32'(pout), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_readdata", rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        tick(LAT + 2);
        chk("post_rst_irq", 32'(irq), 32'h0);
        bus_rd(3'd5, 32'h020, "post_rst_cap");
        bus_rd(3'd4, 32'h0, "post_rst_mask");
        bus_rd(3'd6, 32'h0, "post_rst_cfg");
        bus_rd(3'd1, 32'h0, "post_rst_dout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
